// File: rtl/simon_host_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : simon_host_driver                                            |
// | Brief   : Host-side initiator for the SIMON 64/96 core. It gathers key |
// |           and block words from a 32-bit stream, runs the load/done     |
// |           handshake and streams the two result words out.             |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module simon_host_driver #(
    parameter int N   = 32,
    parameter int M   = 3,
    parameter int TO  = 255,
    parameter int TOb = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [N-1:0]     in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             newKey,
    output logic             newData,
    output logic             enc_dec,
    output logic             readData,
    output logic [M*N-1:0]   key,
    output logic [2*N-1:0]   inData,
    input  logic             loadKey,
    input  logic             doneKey,
    input  logic             loadData,
    input  logic             doneData,
    input  logic [2*N-1:0]   outData,
    output logic             key_ok,
    output logic             busy,
    output logic             err
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0]  c_cnt_last = CW'(M - 1);
    localparam logic [TOb-1:0] c_wd_max   = TOb'(TO);
    // Expiry is tested one count early so the abort edge is the one on which
    // the count would reach TO.
    localparam logic [TOb-1:0] c_wd_lim   = TOb'(TO - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_KEY_COL  = 4'd1,
        S_KEY_REQ  = 4'd2,
        S_KEY_WAIT = 4'd3,
        S_BLK_COL  = 4'd4,
        S_BLK_REQ  = 4'd5,
        S_BLK_WAIT = 4'd6,
        S_OUT0     = 4'd7,
        S_OUT1     = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TOb-1:0]         wd_q, wd_d;
    logic [M-1:0][N-1:0]    key_q, key_d;
    logic [1:0][N-1:0]      data_q, data_d;
    logic [1:0][N-1:0]      res_q, res_d;
    logic                   enc_q, enc_d;
    logic                   key_ok_q, key_ok_d;
    logic                   err_q, err_d;
    logic                   rd_q, rd_d;
    logic                   cmd_rdy_q, cmd_rdy_d;

    logic                   w_wait;
    logic                   w_wd_exp;

    assign w_wait   = (state_q == S_KEY_REQ) || (state_q == S_KEY_WAIT) ||
                      (state_q == S_BLK_REQ) || (state_q == S_BLK_WAIT);
    assign w_wd_exp = (wd_q >= c_wd_lim);

    always_ff @(posedge clk) begin
        if (R) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            key_q     <= '0;
            data_q    <= '0;
            res_q     <= '0;
            enc_q     <= 1'b0;
            key_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            key_q     <= key_d;
            data_q    <= data_d;
            res_q     <= res_d;
            enc_q     <= enc_d;
            key_ok_q  <= key_ok_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        key_d    = key_q;
        data_d   = data_q;
        res_d    = res_q;
        enc_d    = enc_q;
        key_ok_d = key_ok_q;
        err_d    = 1'b0;
        rd_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_rdy_q) begin
                    case (cmd_op)
                        2'b00: begin
                            state_d  = S_KEY_COL;
                            cnt_d    = '0;
                            key_ok_d = 1'b0;
                        end
                        2'b01, 2'b10: begin
                            if (key_ok_q) begin
                                state_d = S_BLK_COL;
                                cnt_d   = '0;
                                enc_d   = (cmd_op == 2'b01);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_KEY_COL: begin
                if (in_valid) begin
                    key_d[cnt_q] = in_word;
                    if (cnt_q == c_cnt_last) begin
                        state_d = S_KEY_REQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_KEY_REQ: begin
                // A handshake seen on the expiry cycle still wins over the abort.
                if (loadKey) begin
                    if (doneKey) begin
                        key_ok_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_KEY_WAIT;
                    end
                end else if (w_wd_exp) begin
                    err_d    = 1'b1;
                    key_ok_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_KEY_WAIT: begin
                if (doneKey) begin
                    key_ok_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (w_wd_exp) begin
                    err_d    = 1'b1;
                    key_ok_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_BLK_COL: begin
                if (in_valid) begin
                    data_d[cnt_q[0]] = in_word;
                    if (cnt_q[0]) begin
                        state_d = S_BLK_REQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BLK_REQ: begin
                if (loadData) begin
                    if (doneData) begin
                        res_d   = outData;
                        rd_d    = 1'b1;
                        state_d = S_OUT0;
                    end else begin
                        state_d = S_BLK_WAIT;
                    end
                end else if (w_wd_exp) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BLK_WAIT: begin
                if (doneData) begin
                    res_d   = outData;
                    rd_d    = 1'b1;
                    state_d = S_OUT0;
                end else if (w_wd_exp) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OUT0: begin
                if (out_ready) state_d = S_OUT1;
            end
            S_OUT1: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog restarts on every state change and saturates while waiting.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (w_wait && (wd_q != c_wd_max)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Registered from the next state so it stays low for the cycle after reset.
    assign cmd_rdy_d = (state_d == S_IDLE);

    assign cmd_ready = cmd_rdy_q;
    assign in_ready  = (state_q == S_KEY_COL) || (state_q == S_BLK_COL);
    assign out_valid = (state_q == S_OUT0) || (state_q == S_OUT1);
    assign out_word  = (state_q == S_OUT0) ? res_q[0] :
                       (state_q == S_OUT1) ? res_q[1] : '0;
    assign newKey    = (state_q == S_KEY_REQ);
    assign newData   = (state_q == S_BLK_REQ);
    assign enc_dec   = enc_q;
    assign readData  = rd_q;
    assign key       = key_q;
    assign inData    = data_q;
    assign key_ok    = key_ok_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_host_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_simon_host_driver                                         |
// | Brief   : Self-checking bench for simon_host_driver with a scripted    |
// |           core model and expected values built from the stream rules.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_simon_host_driver;

    localparam int N   = 32;
    localparam int M   = 3;
    localparam int TO  = 255;
    localparam int TOb = 8;

    logic             clk = 1'b0;
    logic             R = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_ready;
    logic [N-1:0]     in_word = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     out_word;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             newKey, newData, enc_dec, readData;
    logic [M*N-1:0]   key;
    logic [2*N-1:0]   inData;
    logic             loadKey = 1'b0, doneKey = 1'b0;
    logic             loadData = 1'b0, doneData = 1'b0;
    logic [2*N-1:0]   outData = '0;
    logic             key_ok, busy, err;

    int total = 0;
    int bad   = 0;
    logic             exp_key_ok = 1'b0;
    logic [N-1:0]     kw [M];

    simon_host_driver #(.N(N), .M(M), .TO(TO), .TOb(TOb)) dut (
        .clk(clk), .R(R), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .key(key), .inData(inData), .loadKey(loadKey), .doneKey(doneKey),
        .loadData(loadData), .doneData(doneData), .outData(outData),
        .key_ok(key_ok), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("cmd_handshake", ok, 1'b1);
    endtask

    task automatic send_word(input logic [N-1:0] w);
        bit ok = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
        in_valid = 1'b1;
        in_word  = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("in_handshake", ok, 1'b1);
    endtask

    task automatic load_key(input bit together, input int done_dly);
        logic [M*N-1:0] ek;
        for (int i = 0; i < M; i++) ek[i*N +: N] = kw[i];
        send_cmd(2'b00);
        chk("keycol_in_ready", in_ready, 1'b1);
        chk("keycol_key_ok_clr", key_ok, 1'b0);
        for (int i = 0; i < M; i++) send_word(kw[i]);
        chk("keyreq_newKey", newKey, 1'b1);
        chk("keyreq_key", key, ek);
        chk("keyreq_in_ready", in_ready, 1'b0);
        repeat (2) begin
            tick();
            chk("keyreq_hold", {newKey, key}, {1'b1, ek});
        end
        loadKey = 1'b1;
        doneKey = together;
        tick();
        loadKey = 1'b0;
        doneKey = 1'b0;
        chk("key_newKey_drop", newKey, 1'b0);
        if (!together) begin
            repeat (done_dly - 3) tick();
            chk("keywait_state", {key_ok, busy}, 2'b01);
            doneKey = 1'b1;
            tick();
            doneKey = 1'b0;
        end
        exp_key_ok = 1'b1;
        chk("key_done", {key_ok, busy, cmd_ready}, {exp_key_ok, 1'b0, 1'b1});
    endtask

    task automatic run_block(input logic [1:0] op, input logic [N-1:0] d0, input logic [N-1:0] d1,
                             input logic [2*N-1:0] res, input bit together, input int bp);
        send_cmd(op);
        chk("blkcol_state", {in_ready, busy, cmd_ready}, 3'b110);
        send_word(d0);
        send_word(d1);
        chk("blkreq_newData", newData, 1'b1);
        chk("blkreq_inData", inData, {d1, d0});
        chk("blkreq_enc_dec", enc_dec, (op == 2'b01));
        tick();
        chk("blkreq_hold", {newData, inData}, {1'b1, d1, d0});
        loadData = 1'b1;
        doneData = together;
        outData  = res;
        tick();
        loadData = 1'b0;
        doneData = 1'b0;
        if (!together) begin
            chk("blkwait_state", {newData, readData, out_valid}, 3'b000);
            repeat (3) tick();
            doneData = 1'b1;
            tick();
            doneData = 1'b0;
        end
        outData = {$urandom, $urandom};
        chk("res_readData", readData, 1'b1);
        chk("res_word0", {out_valid, out_word}, {1'b1, res[N-1:0]});
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_hold", {out_valid, out_word, readData, cmd_ready},
                {1'b1, res[N-1:0], 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        tick();
        chk("res_word1", {out_valid, out_word, readData}, {1'b1, res[2*N-1:N], 1'b0});
        tick();
        out_ready = 1'b0;
        chk("res_done", {out_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        int n;
        logic [1:0] op;

        repeat (2) tick();
        chk("reset_flags", {cmd_ready, in_ready, out_valid, newKey, newData, enc_dec,
                            readData, key_ok, busy, err}, 10'b0);
        chk("reset_data", {out_word, key, inData}, '0);
        R = 1'b0;
        tick();
        chk("idle_cmd_ready", {cmd_ready, busy}, 2'b10);

        send_cmd(2'b10);
        chk("nokey_err", {err, in_ready, busy, cmd_ready}, 4'b1001);
        tick();
        chk("nokey_err_pulse", {err, in_ready}, 2'b00);
        send_cmd(2'b11);
        chk("reserved_err", {err, busy}, 2'b10);
        tick();

        kw[0] = 32'h03020100; kw[1] = 32'h0B0A0908; kw[2] = 32'h13121110;
        load_key(1'b0, 10);
        run_block(2'b01, 32'h6F722067, 32'h6E696C63, 64'h5CA2E27F_111A8FC8, 1'b0, 5);

        for (int it = 0; it < 6; it++) begin
            if (it == 3) begin
                for (int i = 0; i < M; i++) kw[i] = $urandom;
                load_key(1'b1, 0);
            end
            op = 2'($urandom_range(1, 2));
            run_block(op, $urandom, $urandom, {$urandom, $urandom},
                      1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        loadKey = 1'b1; doneKey = 1'b1; loadData = 1'b1; doneData = 1'b1;
        tick();
        loadKey = 1'b0; doneKey = 1'b0; loadData = 1'b0; doneData = 1'b0;
        tick();
        chk("stray_ignored", {busy, readData, newKey, out_valid, key_ok, err},
            {5'b00000, exp_key_ok, 1'b0});

        send_cmd(2'b01);
        send_word($urandom);
        send_word($urandom);
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        chk("wd_blk_cycles", n, TO);
        chk("wd_blk_state", {busy, newData, key_ok}, {2'b00, exp_key_ok});
        tick();
        chk("wd_blk_pulse", err, 1'b0);

        send_cmd(2'b00);
        for (int i = 0; i < M; i++) send_word(kw[i]);
        loadKey = 1'b1;
        tick();
        loadKey = 1'b0;
        exp_key_ok = 1'b0;
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        chk("wd_key_cycles", n, TO);
        chk("wd_key_state", {busy, newKey, key_ok}, {2'b00, exp_key_ok});
        tick();
        chk("wd_key_pulse", err, 1'b0);

        load_key(1'b0, 6);
        send_cmd(2'b01);
        send_word($urandom);
        send_word($urandom);
        loadData = 1'b1;
        tick();
        loadData = 1'b0;
        tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        exp_key_ok = 1'b0;
        chk("midreset_flags", {cmd_ready, in_ready, out_valid, newKey, newData, enc_dec,
                               readData, key_ok, busy, err}, 10'b0);
        chk("midreset_data", {out_word, key, inData}, '0);
        tick();
        send_cmd(2'b01);
        chk("midreset_reject", {err, busy, in_ready, key_ok}, {3'b100, exp_key_ok});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_host_driver.md
Name: simon_host_driver

Overview:
- Host-side initiator that drives the SIMON 64/96 cipher core's load/done handshake from a narrow word stream.
- Accepts a command (load key / encrypt / decrypt), gathers key or block words from a 32-bit input stream, and presents them to the core.
- Waits for the core's completion, acknowledges the result, and streams the two result words out.
- Sits between the system bus adapter and the cipher core instance.

Parameters:
- N, 32, word width in bits.
- M, 3, number of key words.
- TO, 255, watchdog limit in cycles for any core wait state.
- TOb, 8, watchdog counter width.

Ports:
- clk  in  1  clock
- R  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_op  in  2  00 load key, 01 encrypt, 10 decrypt, 11 reserved
- cmd_ready  out  1  command accepted when valid&ready
- in_word  in  N  input stream word
- in_valid  in  1  input word valid
- in_ready  out  1  input word consumed when valid&ready
- out_word  out  N  result stream word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts word
- newKey  out  1  to core: key presented
- newData  out  1  to core: block presented
- enc_dec  out  1  to core: 1 = encrypt, 0 = decrypt
- readData  out  1  to core: result acknowledged
- key  out  M*N  to core: key words, key[0] = first received
- inData  out  2*N  to core: inData[0] = first received
- loadKey  in  1  core captured key
- doneKey  in  1  core key expansion complete
- loadData  in  1  core captured block
- doneData  in  1  core result valid on outData
- outData  in  2*N  core result
- key_ok  out  1  valid key resident in core
- busy  out  1  not in IDLE
- err  out  1  one-cycle error pulse

Behaviour:
- Reset (R high at a clk edge): state IDLE. All outputs are 0: cmd_ready, in_ready, out_valid, out_word, newKey, newData, enc_dec, readData, key, inData, key_ok, busy, err. Word and watchdog counters are cleared.
- Reset mid-operation aborts the current operation immediately. key_ok clears, so the core key must be reloaded.
- IDLE: cmd_ready = 1.
  - Op 00 → KEY_COL, word count = 0, key_ok cleared.
  - Op 01/10 with key_ok = 1 → BLK_COL; enc_dec is latched.
  - Op 01/10 with key_ok = 0 → err pulse, stay IDLE.
  - Op 11 → err pulse, stay IDLE.
- KEY_COL: in_ready = 1. Each accepted word writes key[count]. After word M-1 → KEY_REQ.
- KEY_REQ: newKey = 1 and key held stable until loadKey = 1. Then newKey drops on the next cycle → KEY_WAIT.
- KEY_WAIT: on doneKey = 1, key_ok is set → IDLE.
- BLK_COL: in_ready = 1. Two words are accepted into inData[0] then inData[1] → BLK_REQ.
- BLK_REQ: newData = 1 with inData and enc_dec stable until loadData → BLK_WAIT.
- BLK_WAIT: on doneData = 1, outData is registered internally and readData = 1 for exactly one cycle → OUT0.
- OUT0/OUT1: out_valid = 1 and out_word = result[0] then result[1], each held until out_ready = 1. After OUT1 → IDLE.
  - out_word/out_valid must not change while out_valid & !out_ready.
  - The result register is independent of core outData after capture.
- Watchdog: counts cycles spent in KEY_REQ, KEY_WAIT, BLK_REQ and BLK_WAIT, and clears on each state entry.
  - When the count reaches TO: err pulse, newKey/newData deasserted → IDLE.
  - A timeout in the key states also clears key_ok.
  - The counter saturates; it does not wrap.
- Simultaneous loadKey and doneKey while in KEY_REQ: treat as load, then doneKey completes on that same transition. KEY_WAIT is skipped and key_ok is set.
- Simultaneous loadData and doneData while in BLK_REQ: the result is captured, and readData pulses next cycle.
- Stray loadX/doneX pulses outside their wait states are ignored.
- busy = (state != IDLE). in_ready is 0 outside the COL states. cmd_ready is 0 outside IDLE.
- Latency from the last result word handshake to cmd_ready = 1: one cycle.

Test Plan:
- Key load: op 00, words 0x03020100, 0x0B0A0908, 0x13121110; core model asserts loadKey after 2 cycles and doneKey after 10 → key = {0x13121110, 0x0B0A0908, 0x03020100}, newKey high until loadKey, key_ok = 1, IDLE.
- Encrypt: op 01, words 0x6F722067, 0x6E696C63; model returns outData {0x5CA2E27F, 0x111A8FC8} → enc_dec = 1, readData single pulse, out_word 0x111A8FC8 then 0x5CA2E27F (result[0] first).
- Backpressure: out_ready low for 5 cycles during OUT0 → out_word/out_valid stable, no readData re-pulse, cmd_ready stays 0.
- Decrypt without key: reset, then op 10 → err pulse for 1 cycle, in_ready never 1, state IDLE.
- Watchdog: key load, model never asserts doneKey → err at TO = 255 cycles after KEY_WAIT entry, key_ok = 0, IDLE.
- Reset mid-block: assert R during BLK_WAIT → next cycle all outputs 0, key_ok = 0; a subsequent op 01 is rejected with err.
